// File: rtl/key_search_scheduler_if.sv
// Handshake bundle between the key search scheduler and its array of decrypt cores.
// The scheduler side uses the master modport, the cores use the slave modport.
`timescale 1ns/1ps
interface key_search_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
);
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic [KEY_W-1:0]     key_out;
  logic [NUM_CORES-1:0] result_valid;
  logic [NUM_CORES-1:0] result_match;
  logic                 abort;

  modport master (
    input  req, result_valid, result_match,
    output grant, key_out, abort
  );

  modport slave (
    output req, result_valid, result_match,
    input  grant, key_out, abort
  );
endinterface

// File: rtl/key_search_scheduler.sv
// Round-robin key dispatcher over [KEY_LOWER, KEY_UPPER]; stops on first match or exhaustion.
// Optional feature macro KEY_SCHED_STATS_EN enables the keys_tried result counter.
`timescale 1ns/1ps
module key_search_scheduler #(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_LOWER = '0,
  parameter logic [KEY_W-1:0] KEY_UPPER = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  key_search_scheduler_if.master cores,
  output logic                 busy,
  output logic                 success,
  output logic                 failure,
  output logic [KEY_W-1:0]     found_key,
  output logic [KEY_W:0]       keys_tried
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    SUCCESS,
    FAIL
  } state_t;

  state_t state, state_nxt;

  logic                 start_d;
  logic [KEY_W:0]       next_key;
  logic [NUM_CORES-1:0] outstanding;
  logic [IDX_W-1:0]     rr_ptr;
  logic [KEY_W-1:0]     key_table [NUM_CORES];
  logic [NUM_CORES-1:0] grant_r;
  logic [KEY_W-1:0]     key_out_r;
  logic                 abort_r;
  logic [KEY_W-1:0]     found_key_r;

  logic                 start_edge;
  logic                 active;
  logic                 restart;
  logic [NUM_CORES-1:0] accepted;
  logic [NUM_CORES-1:0] matched;
  logic                 match_any;
  logic [IDX_W-1:0]     match_idx;
  logic [NUM_CORES-1:0] eligible;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic [NUM_CORES-1:0] grant_vec;
  logic [IDX_W-1:0]     rr_next;
  logic                 do_grant;
  logic                 last_grant;
  logic [NUM_CORES-1:0] outstanding_after;

  assign start_edge        = start & ~start_d;
  assign active            = (state == DISPATCH) || (state == DRAIN);
  assign restart           = start_edge && !active;
  assign accepted          = active ? (cores.result_valid & outstanding) : '0;
  assign matched           = accepted & cores.result_match;
  assign match_any         = |matched;
  assign eligible          = cores.req & ~outstanding;
  assign outstanding_after = outstanding & ~accepted;
  // A match in the same cycle suppresses the grant, so no key is issued after a hit.
  assign do_grant          = (state == DISPATCH) && !match_any && grant_found;
  assign last_grant        = do_grant && (next_key == {1'b0, KEY_UPPER});
  assign rr_next           = (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    match_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (matched[i]) match_idx = IDX_W'(i);
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    grant_vec   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (int'(rr_ptr) + k >= NUM_CORES) cand_idx = IDX_W'(int'(rr_ptr) + k - NUM_CORES);
      else                               cand_idx = IDX_W'(int'(rr_ptr) + k);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, SUCCESS, FAIL: if (start_edge) state_nxt = DISPATCH;
      DISPATCH: begin
        if (match_any)       state_nxt = SUCCESS;
        else if (last_grant) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (match_any)                   state_nxt = SUCCESS;
        else if (outstanding_after == '0) state_nxt = FAIL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      next_key    <= {1'b0, KEY_LOWER};
      outstanding <= '0;
      rr_ptr      <= '0;
      grant_r     <= '0;
      key_out_r   <= '0;
      abort_r     <= 1'b0;
      found_key_r <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_table[i] <= '0;
    end else begin
      state     <= state_nxt;
      start_d   <= start;
      grant_r   <= '0;
      key_out_r <= '0;
      abort_r   <= 1'b0;
      if (restart) begin
        next_key    <= {1'b0, KEY_LOWER};
        outstanding <= '0;
        rr_ptr      <= '0;
        found_key_r <= '0;
      end else begin
        if (match_any) begin
          found_key_r <= key_table[match_idx];
          abort_r     <= 1'b1;
        end
        outstanding <= outstanding_after | (do_grant ? grant_vec : '0);
        if (do_grant) begin
          grant_r              <= grant_vec;
          key_out_r            <= next_key[KEY_W-1:0];
          key_table[grant_idx] <= next_key[KEY_W-1:0];
          next_key             <= next_key + 1'b1;
          rr_ptr               <= rr_next;
        end
      end
    end
  end

`ifdef KEY_SCHED_STATS_EN
  logic [KEY_W:0] tried_cnt;
  logic [KEY_W:0] accepted_cnt;

  always_comb begin
    accepted_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) accepted_cnt = accepted_cnt + (KEY_W+1)'(accepted[i]);
  end

  // Accepted results only arrive while searching, so the count freezes in SUCCESS/FAIL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tried_cnt <= '0;
    else if (restart) tried_cnt <= '0;
    else if (active)  tried_cnt <= tried_cnt + accepted_cnt;
  end

  assign keys_tried = tried_cnt;
`else
  assign keys_tried = '0;
`endif

  assign cores.grant   = grant_r;
  assign cores.key_out = key_out_r;
  assign cores.abort   = abort_r;
  assign busy          = active;
  assign success       = (state == SUCCESS);
  assign failure       = (state == FAIL);
  assign found_key     = found_key_r;

endmodule
